// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } dmem_state_e;

  localparam logic [3:0]  WE_READ    = 4'b0000;
  localparam int unsigned BYTE_WIDTH = 8;

endpackage

// File: rtl/dmem_ram_array.sv
// Synchronous single-port word RAM with per-byte write enables.
module dmem_ram_array
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [31:0] mem [Depth];
  logic [31:0] rdata_q;

  // Read-first; rdata only matters for reads, where no lane is written.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-bus responder: wait-state FSM in front of a byte-writable word RAM.
// Optional completed-access counters enabled by defining DMEM_PERF_CNT_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [3:0]  we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam logic [3:0] CntLoad = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  we_q;
  logic [31:0] addr_q, wdata_q;

  logic        accept, fire, acc_err, resp_err, ram_en;
  logic [3:0]  acc_we;
  logic [31:0] acc_addr, acc_wdata, ram_rdata;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:ADDR_WIDTH+2] != '0);
  endfunction

  assign accept = req && ((state_q == StIdle) || (state_q == StResp));

  // With zero wait states the access fires on the accept edge straight from the inputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fire      = 1'b0;
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    unique case (state_q)
      StIdle, StResp: begin
        state_d = StIdle;
        if (req) begin
          cnt_d = CntLoad;
          if (WAIT_STATES == 0) begin
            state_d   = StResp;
            fire      = 1'b1;
            acc_we    = we;
            acc_addr  = addr;
            acc_wdata = wdata;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          fire    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign acc_err = addr_bad(acc_addr);
  assign ram_en  = fire && !acc_err && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end

  dmem_ram_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (acc_we),
    .addr (acc_addr[ADDR_WIDTH+1:2]),
    .wdata(acc_wdata),
    .rdata(ram_rdata)
  );

  // The latches still describe the responding access during StResp.
  assign resp_err = addr_bad(addr_q);
  assign ready    = (state_q == StResp);
  assign busy     = (state_q == StWait);
  assign err      = ready && resp_err;
  assign rdata    = (ready && !resp_err && (we_q == WE_READ)) ? ram_rdata : '0;

`ifdef DMEM_PERF_CNT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (fire && !acc_err) begin
      if (acc_we == WE_READ) rd_cnt_q <= rd_cnt_q + 32'd1;
      else                   wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule
